// File: rtl/dfi_phase_injector.sv
// Single-command DFI injector: places one command on a chosen phase, then drives
// write data or read enable and captures the PHY's read response with latency/timeout.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// CMD     | command visible on the selected DFI phase (cycle T)
// WAIT_WR | counting down to the wrdata_en cycle (T+WRLAT)
// WAIT_RD | counting latency until rddata_valid or TIMEOUT
// DONE    | one-cycle rsp_valid pulse
module dfi_phase_injector #(
  parameter int NPHASES  = 4,
  parameter int ADDRBITS = 15,
  parameter int BANKBITS = 3,
  parameter int DATABITS = 64,
  parameter int WRLAT    = 2,
  parameter int TIMEOUT  = 32,
  localparam int PHASEBITS = (NPHASES > 1) ? $clog2(NPHASES) : 1
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [PHASEBITS-1:0]           cmd_phase,
  input  logic                           cmd_ras_n,
  input  logic                           cmd_cas_n,
  input  logic                           cmd_we_n,
  input  logic [ADDRBITS-1:0]            cmd_address,
  input  logic [BANKBITS-1:0]            cmd_bank,
  input  logic [NPHASES*DATABITS-1:0]    cmd_wrdata,
  input  logic                           cfg_cke,
  input  logic                           cfg_odt,
  input  logic                           cfg_reset_n,
  output logic [NPHASES*ADDRBITS-1:0]    dfi_address,
  output logic [NPHASES*BANKBITS-1:0]    dfi_bank,
  output logic [NPHASES-1:0]             dfi_cs_n,
  output logic [NPHASES-1:0]             dfi_ras_n,
  output logic [NPHASES-1:0]             dfi_cas_n,
  output logic [NPHASES-1:0]             dfi_we_n,
  output logic [NPHASES-1:0]             dfi_cke,
  output logic [NPHASES-1:0]             dfi_odt,
  output logic [NPHASES-1:0]             dfi_reset_n,
  output logic [NPHASES*DATABITS-1:0]    dfi_wrdata,
  output logic [NPHASES-1:0]             dfi_wrdata_en,
  output logic [NPHASES*DATABITS/8-1:0]  dfi_wrdata_mask,
  output logic [NPHASES-1:0]             dfi_rddata_en,
  input  logic [NPHASES*DATABITS-1:0]    dfi_rddata,
  input  logic [NPHASES-1:0]             dfi_rddata_valid,
  output logic                           rsp_valid,
  output logic                           rsp_timeout,
  output logic [7:0]                     rsp_latency,
  output logic [NPHASES*DATABITS-1:0]    rsp_data,
  output logic [7:0]                     stray_count
);

  localparam int WCW = (WRLAT > 1) ? $clog2(WRLAT) : 1;

  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_WR,
    S_WAIT_RD,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [1:0]                  op_q;
  logic [NPHASES*DATABITS-1:0] wrdata_q;
  logic [WCW-1:0]              wr_cnt;
  logic [7:0]                  lat_cnt;
  logic                        accept;
  logic                        rd_hit;
  logic                        rd_expire;

  logic [NPHASES*ADDRBITS-1:0] nxt_address;
  logic [NPHASES*BANKBITS-1:0] nxt_bank;
  logic [NPHASES-1:0]          nxt_cs_n;
  logic [NPHASES-1:0]          nxt_ras_n;
  logic [NPHASES-1:0]          nxt_cas_n;
  logic [NPHASES-1:0]          nxt_we_n;
  logic [NPHASES*DATABITS-1:0] nxt_wrdata;
  logic [NPHASES-1:0]          nxt_wrdata_en;
  logic [NPHASES-1:0]          nxt_rddata_en;

  assign dfi_wrdata_mask = '0;
  assign rd_hit    = |dfi_rddata_valid;
  assign rd_expire = (lat_cnt == 8'(TIMEOUT));

  // Output registers hold the value for the cycle we are about to enter, so the
  // command fields are taken live from cmd_* in the acceptance cycle.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    nxt_address   = '0;
    nxt_bank      = '0;
    nxt_cs_n      = '1;
    nxt_ras_n     = '1;
    nxt_cas_n     = '1;
    nxt_we_n      = '1;
    nxt_wrdata    = '0;
    nxt_wrdata_en = '0;
    nxt_rddata_en = '0;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          next_state = S_CMD;
          for (int i = 0; i < NPHASES; i++) begin
            if (cmd_phase == PHASEBITS'(i)) begin
              nxt_cs_n[i] = 1'b0;
              nxt_address[i*ADDRBITS +: ADDRBITS] = cmd_address;
              nxt_bank[i*BANKBITS +: BANKBITS]    = cmd_bank;
              case (cmd_op)
                OP_WRITE: begin
                  nxt_ras_n[i] = 1'b1;
                  nxt_cas_n[i] = 1'b0;
                  nxt_we_n[i]  = 1'b0;
                end
                OP_READ: begin
                  nxt_ras_n[i] = 1'b1;
                  nxt_cas_n[i] = 1'b0;
                  nxt_we_n[i]  = 1'b1;
                end
                default: begin
                  nxt_ras_n[i] = cmd_ras_n;
                  nxt_cas_n[i] = cmd_cas_n;
                  nxt_we_n[i]  = cmd_we_n;
                end
              endcase
            end
          end
          if (cmd_op == OP_READ) nxt_rddata_en = '1;
        end
      end
      S_CMD: begin
        if (op_q == OP_WRITE) begin
          next_state = S_WAIT_WR;
          if (WRLAT == 1) begin
            nxt_wrdata_en = '1;
            nxt_wrdata    = wrdata_q;
          end
        end else if (op_q == OP_READ) begin
          next_state = S_WAIT_RD;
        end else begin
          next_state = S_DONE;
        end
      end
      S_WAIT_WR: begin
        if (wr_cnt == '0) begin
          next_state = S_DONE;
        end else if (wr_cnt == WCW'(1)) begin
          nxt_wrdata_en = '1;
          nxt_wrdata    = wrdata_q;
        end
      end
      S_WAIT_RD: begin
        if (rd_hit || rd_expire) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      op_q     <= '0;
      wrdata_q <= '0;
      wr_cnt   <= '0;
      lat_cnt  <= '0;
    end else begin
      if (accept) begin
        op_q     <= cmd_op;
        wrdata_q <= cmd_wrdata;
      end
      if (state == S_CMD)                        wr_cnt <= WCW'(WRLAT - 1);
      else if (state == S_WAIT_WR && wr_cnt != '0) wr_cnt <= wr_cnt - WCW'(1);
      if (state == S_CMD)          lat_cnt <= 8'd1;
      else if (state == S_WAIT_RD) lat_cnt <= lat_cnt + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cmd_ready     <= 1'b0;
      dfi_address   <= '0;
      dfi_bank      <= '0;
      dfi_cs_n      <= '1;
      dfi_ras_n     <= '1;
      dfi_cas_n     <= '1;
      dfi_we_n      <= '1;
      dfi_cke       <= '0;
      dfi_odt       <= '0;
      dfi_reset_n   <= '0;
      dfi_wrdata    <= '0;
      dfi_wrdata_en <= '0;
      dfi_rddata_en <= '0;
    end else begin
      cmd_ready     <= (next_state == S_IDLE);
      dfi_address   <= nxt_address;
      dfi_bank      <= nxt_bank;
      dfi_cs_n      <= nxt_cs_n;
      dfi_ras_n     <= nxt_ras_n;
      dfi_cas_n     <= nxt_cas_n;
      dfi_we_n      <= nxt_we_n;
      dfi_cke       <= {NPHASES{cfg_cke}};
      dfi_odt       <= {NPHASES{cfg_odt}};
      dfi_reset_n   <= {NPHASES{cfg_reset_n}};
      dfi_wrdata    <= nxt_wrdata;
      dfi_wrdata_en <= nxt_wrdata_en;
      dfi_rddata_en <= nxt_rddata_en;
    end
  end

  // A valid arriving in the TIMEOUT cycle wins over the timeout.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_latency <= '0;
      rsp_data    <= '0;
      stray_count <= '0;
    end else begin
      rsp_valid <= (next_state == S_DONE);
      if (state == S_WAIT_RD && next_state == S_DONE) begin
        if (rd_hit) begin
          rsp_data    <= dfi_rddata;
          rsp_latency <= lat_cnt;
          rsp_timeout <= 1'b0;
        end else begin
          rsp_data    <= '0;
          rsp_latency <= 8'(TIMEOUT);
          rsp_timeout <= 1'b1;
        end
      end else if (next_state == S_DONE) begin
        rsp_latency <= '0;
        rsp_timeout <= 1'b0;
      end
      if (rd_hit && state != S_WAIT_RD && stray_count != 8'hFF)
        stray_count <= stray_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dfi_phase_injector.sv
// Directed bench for dfi_phase_injector: 4 phases, WRLAT=2, TIMEOUT=32.
module tb_dfi_phase_injector;

  localparam int NP = 4;
  localparam int AB = 15;
  localparam int BB = 3;
  localparam int DB = 64;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_phase;
  logic              cmd_ras_n, cmd_cas_n, cmd_we_n;
  logic [AB-1:0]     cmd_address;
  logic [BB-1:0]     cmd_bank;
  logic [NP*DB-1:0]  cmd_wrdata;
  logic              cfg_cke, cfg_odt, cfg_reset_n;
  logic [NP*AB-1:0]  dfi_address;
  logic [NP*BB-1:0]  dfi_bank;
  logic [NP-1:0]     dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [NP-1:0]     dfi_cke, dfi_odt, dfi_reset_n;
  logic [NP*DB-1:0]  dfi_wrdata;
  logic [NP-1:0]     dfi_wrdata_en;
  logic [NP*DB/8-1:0] dfi_wrdata_mask;
  logic [NP-1:0]     dfi_rddata_en;
  logic [NP*DB-1:0]  dfi_rddata;
  logic [NP-1:0]     dfi_rddata_valid;
  logic              rsp_valid, rsp_timeout;
  logic [7:0]        rsp_latency;
  logic [NP*DB-1:0]  rsp_data;
  logic [7:0]        stray_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NP*DB-1:0] pat_a5, pat_dead, pat_two;

  dfi_phase_injector #(
    .NPHASES(NP), .ADDRBITS(AB), .BANKBITS(BB), .DATABITS(DB), .WRLAT(2), .TIMEOUT(32)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_phase(cmd_phase),
    .cmd_ras_n(cmd_ras_n), .cmd_cas_n(cmd_cas_n), .cmd_we_n(cmd_we_n),
    .cmd_address(cmd_address), .cmd_bank(cmd_bank), .cmd_wrdata(cmd_wrdata),
    .cfg_cke(cfg_cke), .cfg_odt(cfg_odt), .cfg_reset_n(cfg_reset_n),
    .dfi_address(dfi_address), .dfi_bank(dfi_bank),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .dfi_cke(dfi_cke), .dfi_odt(dfi_odt), .dfi_reset_n(dfi_reset_n),
    .dfi_wrdata(dfi_wrdata), .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata_mask(dfi_wrdata_mask),
    .dfi_rddata_en(dfi_rddata_en), .dfi_rddata(dfi_rddata), .dfi_rddata_valid(dfi_rddata_valid),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .rsp_latency(rsp_latency),
    .rsp_data(rsp_data), .stray_count(stray_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] ph, input logic [2:0] rcw,
                       input logic [AB-1:0] addr, input logic [BB-1:0] bank,
                       input logic [NP*DB-1:0] wd);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_phase = ph;
    {cmd_ras_n, cmd_cas_n, cmd_we_n} = rcw;
    cmd_address = addr; cmd_bank = bank; cmd_wrdata = wd;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_address = '0; cmd_bank = '0; cmd_wrdata = '0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; cfg_cke = 1'b1; cfg_odt = 1'b1; cfg_reset_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_cmd: %h want ffff", {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n});
    end
    n_checks++;
    if ({dfi_cke, dfi_odt, dfi_reset_n} !== 12'h000) begin
      n_fail++; $display("FAIL reset_ctl: %h want 000", {dfi_cke, dfi_odt, dfi_reset_n});
    end
    n_checks++;
    if (dfi_address !== '0 || dfi_bank !== '0 || dfi_wrdata !== '0 ||
        dfi_wrdata_en !== '0 || dfi_rddata_en !== '0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h bank=%h wen=%h ren=%h want 0",
                         dfi_address, dfi_bank, dfi_wrdata_en, dfi_rddata_en);
    end
    n_checks++;
    if ({rsp_valid, rsp_timeout, rsp_latency, stray_count, cmd_ready} !== 19'h0 || rsp_data !== '0) begin
      n_fail++; $display("FAIL reset_rsp: v=%b to=%b lat=%0d stray=%0d rdy=%b want 0",
                         rsp_valid, rsp_timeout, rsp_latency, stray_count, cmd_ready);
    end
    sys_rst = 1'b0;
    tick();
    n_checks++;
    if ({dfi_cke, dfi_odt, dfi_reset_n, cmd_ready} !== 13'h1FFF) begin
      n_fail++; $display("FAIL post_reset: ctl=%h rdy=%b want fff/1",
                         {dfi_cke, dfi_odt, dfi_reset_n}, cmd_ready);
    end
    cfg_odt = 1'b0;
    tick();
    n_checks++;
    if ({dfi_cke, dfi_odt, dfi_reset_n} !== 12'hF0F) begin
      n_fail++; $display("FAIL ctl_repl: %h want f0f", {dfi_cke, dfi_odt, dfi_reset_n});
    end
  endtask

  task automatic test_raw();
    logic [NP*AB-1:0] exp_addr;
    logic [NP*BB-1:0] exp_bank;
    exp_addr = '0; exp_addr[2*AB +: AB] = 15'h1234;
    exp_bank = '0; exp_bank[2*BB +: BB] = 3'd5;
    issue(2'd0, 2'd2, 3'b011, 15'h1234, 3'd5, '0);
    n_checks++;
    if ({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} !== 16'hBBFF) begin
      n_fail++; $display("FAIL raw_cmd: %h want bbff", {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n});
    end
    n_checks++;
    if (dfi_address !== exp_addr || dfi_bank !== exp_bank) begin
      n_fail++; $display("FAIL raw_addr: addr=%h bank=%h want %h %h", dfi_address, dfi_bank, exp_addr, exp_bank);
    end
    n_checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL raw_T_flags: rdy=%b v=%b want 0 0", cmd_ready, rsp_valid);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || {dfi_cs_n, dfi_ras_n} !== 8'hFF || dfi_address !== '0) begin
      n_fail++; $display("FAIL raw_done: v=%b cs/ras=%h addr=%h want 1 ff 0",
                         rsp_valid, {dfi_cs_n, dfi_ras_n}, dfi_address);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_ready: v=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_write();
    issue(2'd1, 2'd0, 3'b111, 15'h0042, 3'd1, pat_a5);
    n_checks++;
    if ({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} !== 16'hEFEE || dfi_wrdata_en !== 4'h0) begin
      n_fail++; $display("FAIL wr_cmd: %h wen=%h want efee 0",
                         {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_wrdata_en);
    end
    tick();
    n_checks++;
    if (dfi_wrdata_en !== 4'h0 || dfi_wrdata !== '0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_T1: wen=%h v=%b want 0 0", dfi_wrdata_en, rsp_valid);
    end
    tick();
    n_checks++;
    if (dfi_wrdata_en !== 4'hF || dfi_wrdata !== pat_a5 || dfi_wrdata_mask !== '0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_data: wen=%h data=%h v=%b want f %h 0",
                         dfi_wrdata_en, dfi_wrdata, rsp_valid, pat_a5);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || dfi_wrdata_en !== 4'h0 || dfi_wrdata !== '0 || rsp_latency !== 8'd0) begin
      n_fail++; $display("FAIL wr_done: v=%b wen=%h lat=%0d want 1 0 0", rsp_valid, dfi_wrdata_en, rsp_latency);
    end
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_ready: rdy=%b v=%b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_read();
    logic early;
    issue(2'd2, 2'd1, 3'b111, 15'h0100, 3'd2, '0);
    n_checks++;
    if (dfi_rddata_en !== 4'hF || {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} !== 16'hDFDF) begin
      n_fail++; $display("FAIL rd_cmd: ren=%h cmd=%h want f dfdf",
                         dfi_rddata_en, {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n});
    end
    tick();
    n_checks++;
    if (dfi_rddata_en !== 4'h0) begin
      n_fail++; $display("FAIL rd_en_once: ren=%h want 0", dfi_rddata_en);
    end
    early = rsp_valid;
    for (int k = 2; k <= 5; k++) begin
      tick();
      early |= rsp_valid;
    end
    dfi_rddata_valid = 4'hF; dfi_rddata = pat_dead;
    tick();
    dfi_rddata_valid = 4'h0; dfi_rddata = '0;
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++; $display("FAIL rd_early: early rsp_valid=%b want 0", early);
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_latency !== 8'd5) begin
      n_fail++; $display("FAIL rd_rsp: v=%b to=%b lat=%0d want 1 0 5", rsp_valid, rsp_timeout, rsp_latency);
    end
    n_checks++;
    if (rsp_data !== pat_dead || stray_count !== 8'd0) begin
      n_fail++; $display("FAIL rd_data: data=%h stray=%0d want %h 0", rsp_data, stray_count, pat_dead);
    end
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_ready: rdy=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_read_timeout();
    logic early;
    issue(2'd2, 2'd3, 3'b111, 15'h0007, 3'd0, '0);
    early = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      early |= rsp_valid;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++; $display("FAIL to_early: rsp_valid seen before T+33");
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_latency !== 8'd32 || rsp_data !== '0) begin
      n_fail++; $display("FAIL to_rsp: v=%b to=%b lat=%0d data=%h want 1 1 32 0",
                         rsp_valid, rsp_timeout, rsp_latency, rsp_data);
    end
    tick();
  endtask

  task automatic test_read_valid_at_timeout();
    issue(2'd2, 2'd0, 3'b111, 15'h0009, 3'd3, '0);
    repeat (32) tick();
    dfi_rddata_valid = 4'h2; dfi_rddata = pat_two;
    tick();
    dfi_rddata_valid = 4'h0; dfi_rddata = '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_latency !== 8'd32 || rsp_data !== pat_two) begin
      n_fail++; $display("FAIL to_edge: v=%b to=%b lat=%0d data=%h want 1 0 32 %h",
                         rsp_valid, rsp_timeout, rsp_latency, rsp_data, pat_two);
    end
    tick();
  endtask

  task automatic test_reserved_op();
    issue(2'd3, 2'd0, 3'b000, 15'h7FFF, 3'd7, '0);
    n_checks++;
    if ({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} !== 16'hEEEE ||
        dfi_address !== {45'd0, 15'h7FFF} || dfi_bank !== {9'd0, 3'd7} || dfi_rddata_en !== 4'h0) begin
      n_fail++; $display("FAIL rsv_cmd: cmd=%h addr=%h bank=%h ren=%h want eeee 7fff 7 0",
                         {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_address, dfi_bank, dfi_rddata_en);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_latency !== 8'd0) begin
      n_fail++; $display("FAIL rsv_done: v=%b to=%b lat=%0d want 1 0 0", rsp_valid, rsp_timeout, rsp_latency);
    end
    tick();
  endtask

  task automatic test_stray();
    n_checks++;
    if (stray_count !== 8'd0) begin
      n_fail++; $display("FAIL stray_init: %0d want 0", stray_count);
    end
    dfi_rddata_valid = 4'h1;
    repeat (3) tick();
    dfi_rddata_valid = 4'h0;
    n_checks++;
    if (stray_count !== 8'd3) begin
      n_fail++; $display("FAIL stray_3: %0d want 3", stray_count);
    end
    dfi_rddata_valid = 4'h8;
    repeat (300) tick();
    dfi_rddata_valid = 4'h0;
    tick();
    n_checks++;
    if (stray_count !== 8'd255) begin
      n_fail++; $display("FAIL stray_sat: %0d want 255", stray_count);
    end
  endtask

  task automatic test_reset_midop();
    logic seen;
    cfg_cke = 1'b1;
    issue(2'd1, 2'd2, 3'b111, 15'h0055, 3'd4, pat_a5);
    tick();
    sys_rst = 1'b1;
    tick();
    n_checks++;
    if ({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} !== 16'hFFFF || dfi_wrdata_en !== 4'h0 ||
        dfi_cke !== 4'h0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_bus: cmd=%h wen=%h cke=%h v=%b rdy=%b want ffff 0 0 0 0",
                         {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_wrdata_en, dfi_cke, rsp_valid, cmd_ready);
    end
    n_checks++;
    if (stray_count !== 8'd0 || rsp_data !== '0 || dfi_address !== '0) begin
      n_fail++; $display("FAIL midrst_rsp: stray=%0d data=%h want 0 0", stray_count, rsp_data);
    end
    sys_rst = 1'b0;
    tick();
    n_checks++;
    if (dfi_cke !== 4'hF || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_release: cke=%h rdy=%b want f 1", dfi_cke, cmd_ready);
    end
    seen = 1'b0;
    repeat (4) begin
      seen |= rsp_valid | (|dfi_wrdata_en);
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL midrst_abort: rsp_valid/wrdata_en seen=%b want 0", seen);
    end
  endtask

  initial begin
    pat_a5   = {32{8'hA5}};
    pat_dead = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    pat_two  = {4{64'h0123_4567_89AB_CDEF}};
    sys_rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_phase = '0;
    cmd_ras_n = 1'b1; cmd_cas_n = 1'b1; cmd_we_n = 1'b1;
    cmd_address = '0; cmd_bank = '0; cmd_wrdata = '0;
    cfg_cke = 1'b0; cfg_odt = 1'b0; cfg_reset_n = 1'b0;
    dfi_rddata = '0; dfi_rddata_valid = '0;
    test_reset();
    test_raw();
    test_write();
    test_read();
    test_read_timeout();
    test_read_valid_at_timeout();
    test_reserved_op();
    test_stray();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
